// File: rtl/rr_pkg.sv
// Shared helpers for the round-robin arbiter and dispatcher blocks:
// pointer wrap-increment and one-hot to index conversion.
package rr_pkg;

   // Widest one-hot vector the index helper accepts. Channel counts above this
   // need a wider helper.
   localparam int unsigned RR_MAX_N = 64;

   // Advance a round-robin index by one, wrapping n-1 back to 0. The modulus
   // can be any value, not only a power of two.
   function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                               input int unsigned n);
      return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
   endfunction

   // OR-reduce form: the result is only meaningful for a one-hot or zero
   // input. A zero input gives index 0.
   function automatic int unsigned onehot_to_idx(input logic [RR_MAX_N-1:0] onehot);
      int unsigned idx;
      idx = 32'd0;
      for (int unsigned i = 0; i < RR_MAX_N; i++) begin
         if (onehot[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_dispatch_pick.sv
// Combinational round-robin pick: the first free channel at or after ptr,
// returned both as a one-hot vector and as an index.
module rr_dispatch_pick
   import rr_pkg::*;
#(
   parameter  int unsigned N  = 8,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  free,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  sel,
   output logic [PW-1:0] sel_idx
);

   logic [2*N-1:0] free_dbl;
   logic [N-1:0]   free_rot;
   logic [N-1:0]   pick_rot;
   logic [2*N-1:0] pick_dbl;

   // The vectors are doubled so that a rotation by any ptr < N stays inside
   // 2N bits. This holds for any N.
   // NOTE: every signal is assigned on every pass through this block, so no
   // latch can be inferred.
   always_comb begin
      free_dbl = {free, free} >> ptr;
      free_rot = free_dbl[N-1:0];
      pick_rot = free_rot & (~free_rot + N'(1));
      pick_dbl = {pick_rot, pick_rot} << ptr;
      sel      = pick_dbl[2*N-1:N];
      sel_idx  = PW'(onehot_to_idx(RR_MAX_N'(sel)));
   end

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: deals one valid/ready stream across N one-entry
// channel slots. Each word goes to the first free channel at or after rr_ptr.
module rr_dispatcher
   import rr_pkg::*;
#(
   parameter  int unsigned N  = 8,
   parameter  int unsigned DW = 32,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic [N-1:0]    out_valid,
   input  logic [N-1:0]    out_ready,
   output logic [N*DW-1:0] out_data,
   output logic [PW-1:0]   rr_ptr
);

   logic [N-1:0]  full;
   logic [N-1:0]  free;
   logic [N-1:0]  sel;
   logic [PW-1:0] sel_idx;
   logic [PW-1:0] ptr;
   logic          accept;

   // in_ready depends only on registered occupancy. There is no path from
   // out_ready to in_ready.
   assign free     = ~full;
   assign in_ready = |free;
   assign accept   = in_valid & in_ready;

   rr_dispatch_pick #(
      .N (N)
   ) u_pick (
      .free    (free),
      .ptr     (ptr),
      .sel     (sel),
      .sel_idx (sel_idx)
   );

   // The pointer moves only when a word is accepted. Idle or stalled cycles
   // leave it unchanged.
   // NOTE: state is updated with non-blocking assignments. Every flop then
   // samples pre-edge values, whatever order the blocks run in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= PW'(rr_wrap_inc(32'(sel_idx), N));
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_slot
      logic          full_q;
      logic [DW-1:0] data_q;

      // A selected slot is never full. An accept and a drain can therefore
      // never target the same slot on one edge.
      // NOTE: the data register is reset as well, so out_data reads 0 after
      // reset. A drain leaves the stale word in place.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
         end else if (accept && sel[i]) begin
            full_q <= 1'b1;
            data_q <= in_data;
         end else if (full_q && out_ready[i]) begin
            full_q <= 1'b0;
         end
      end

      assign full[i]               = full_q;
      assign out_data[i*DW +: DW]  = data_q;
   end

   assign out_valid = full;
   assign rr_ptr    = ptr;

endmodule
